// File: rtl/exe_stage.sv
// Execute stage of the 5-stage ARM pipeline: Val2 generation, ALU, NZCV register,
// branch-target adder and the EX/MEM pipeline register.
module exe_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              freeze,
   input  logic              flush,
   input  logic [DATA_W-1:0] pc_in,
   input  logic [3:0]        exe_cmd_in,
   input  logic              mem_read_in,
   input  logic              mem_write_in,
   input  logic              wb_enable_in,
   input  logic              status_update_in,
   input  logic              branch_taken_in,
   input  logic              imm_in,
   input  logic [11:0]       shift_operand_in,
   input  logic [23:0]       signed_imm_24_in,
   input  logic [3:0]        dest_reg_in,
   input  logic [DATA_W-1:0] val_rn_in,
   input  logic [DATA_W-1:0] val_rm_in,
   output logic              branch_taken_out,
   output logic [DATA_W-1:0] branch_addr_out,
   output logic [3:0]        status_out,
   output logic              wb_enable_out,
   output logic              mem_read_out,
   output logic              mem_write_out,
   output logic [DATA_W-1:0] alu_result_out,
   output logic [DATA_W-1:0] st_val_out,
   output logic [3:0]        dest_reg_out
);

   logic [3:0]          status_reg;
   logic                wb_enable_reg;
   logic                mem_read_reg;
   logic                mem_write_reg;
   logic [DATA_W-1:0]   alu_result_reg;
   logic [DATA_W-1:0]   st_val_reg;
   logic [3:0]          dest_reg_reg;

   logic [4:0]          shift_amt;
   logic [1:0]          shift_type;
   logic [4:0]          imm_rot_amt;
   logic [2*DATA_W-1:0] imm_rot_wide;
   logic [2*DATA_W-1:0] rm_rot_wide;
   logic [DATA_W-1:0]   imm_base;
   logic [DATA_W-1:0]   val2;

   logic [DATA_W:0]     sum_next;
   logic [DATA_W-1:0]   result_next;
   logic [DATA_W-1:0]   b_eff;
   logic                arith_next;
   logic                c_next;
   logic                v_next;
   logic                cmd_valid;
   logic                cin;

   assign branch_taken_out = branch_taken_in;
   assign branch_addr_out  = pc_in + {{(DATA_W-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};

   assign shift_amt   = shift_operand_in[11:7];
   assign shift_type  = shift_operand_in[6:5];
   assign imm_rot_amt = {shift_operand_in[11:8], 1'b0};
   assign imm_base    = {{(DATA_W-8){1'b0}}, shift_operand_in[7:0]};

   // Rotations are done by shifting a doubled copy of the word.
   assign imm_rot_wide = {imm_base, imm_base} >> imm_rot_amt;
   assign rm_rot_wide  = {val_rm_in, val_rm_in} >> shift_amt;

   always_comb begin
      val2 = val_rm_in;
      if (imm_in) begin
         val2 = imm_rot_wide[DATA_W-1:0];
      end else if (mem_read_in || mem_write_in) begin
         val2 = {{(DATA_W-12){1'b0}}, shift_operand_in};
      end else if (shift_amt != 5'd0) begin
         case (shift_type)
            2'b00:   val2 = val_rm_in << shift_amt;
            2'b01:   val2 = val_rm_in >> shift_amt;
            2'b10:   val2 = $signed(val_rm_in) >>> shift_amt;
            default: val2 = rm_rot_wide[DATA_W-1:0];
         endcase
      end
   end

   assign cin = status_reg[1];

   always_comb begin
      sum_next    = '0;
      result_next = '0;
      arith_next  = 1'b0;
      b_eff       = val2;
      cmd_valid   = 1'b1;
      case (exe_cmd_in)
         4'b0001: result_next = val2;
         4'b1001: result_next = ~val2;
         4'b0010: begin
            sum_next   = {1'b0, val_rn_in} + {1'b0, val2};
            arith_next = 1'b1;
         end
         4'b0011: begin
            sum_next   = {1'b0, val_rn_in} + {1'b0, val2} + {{DATA_W{1'b0}}, cin};
            arith_next = 1'b1;
         end
         // Subtraction as A + ~B + carry-in, so the carry out is NOT borrow.
         4'b0100: begin
            b_eff      = ~val2;
            sum_next   = {1'b0, val_rn_in} + {1'b0, ~val2} + {{DATA_W{1'b0}}, 1'b1};
            arith_next = 1'b1;
         end
         4'b0101: begin
            b_eff      = ~val2;
            sum_next   = {1'b0, val_rn_in} + {1'b0, ~val2} + {{DATA_W{1'b0}}, cin};
            arith_next = 1'b1;
         end
         4'b0110: result_next = val_rn_in & val2;
         4'b0111: result_next = val_rn_in | val2;
         4'b1000: result_next = val_rn_in ^ val2;
         default: cmd_valid = 1'b0;
      endcase
      if (arith_next) begin
         result_next = sum_next[DATA_W-1:0];
      end
      c_next = arith_next ? sum_next[DATA_W] : status_reg[1];
      v_next = arith_next ? ((val_rn_in[DATA_W-1] == b_eff[DATA_W-1]) &&
                             (result_next[DATA_W-1] != val_rn_in[DATA_W-1]))
                          : status_reg[0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         status_reg <= 4'b0000;
      end else if (status_update_in && !freeze && cmd_valid) begin
         status_reg <= {result_next[DATA_W-1], (result_next == '0), c_next, v_next};
      end
   end

   // Flush only kills the control bits; the data fields still advance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_enable_reg  <= 1'b0;
         mem_read_reg   <= 1'b0;
         mem_write_reg  <= 1'b0;
         alu_result_reg <= '0;
         st_val_reg     <= '0;
         dest_reg_reg   <= 4'd0;
      end else if (!freeze) begin
         wb_enable_reg  <= flush ? 1'b0 : wb_enable_in;
         mem_read_reg   <= flush ? 1'b0 : mem_read_in;
         mem_write_reg  <= flush ? 1'b0 : mem_write_in;
         alu_result_reg <= result_next;
         st_val_reg     <= val_rm_in;
         dest_reg_reg   <= dest_reg_in;
      end
   end

   assign status_out     = status_reg;
   assign wb_enable_out  = wb_enable_reg;
   assign mem_read_out   = mem_read_reg;
   assign mem_write_out  = mem_write_reg;
   assign alu_result_out = alu_result_reg;
   assign st_val_out     = st_val_reg;
   assign dest_reg_out   = dest_reg_reg;

endmodule
